// File: rtl/rv32i_types.sv
// rv32i_types: shared type and constant definitions for the RV32I core datapath.
//
// Contents:
//   alu_ops          - ALU operation select (funct3-based) used by the EX stage
//   muldiv_ops       - M-extension operation select, funct3-encoded
//   muldiv_state_e   - state encoding of the iterative multiply/divide unit
//   DATA_W           - datapath width
//   MULDIV_ITERS     - shift-add / restoring-subtract steps per op
//   DIV_BY_ZERO      - quotient returned by div/divu when the divisor is zero
package rv32i_types;

    localparam int DATA_W       = 32;
    localparam int MULDIV_ITERS = 32;

    localparam logic [DATA_W-1:0] DIV_BY_ZERO = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SLL = 3'b001,
        ALU_SRA = 3'b010,
        ALU_SUB = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SRL = 3'b101,
        ALU_OR  = 3'b110,
        ALU_AND = 3'b111
    } alu_ops;

    // Encoding matches funct3 of the M extension, so bit 2 selects divide
    // and, for divides, bit 1 selects remainder.
    typedef enum logic [2:0] {
        MD_MUL    = 3'b000,
        MD_MULH   = 3'b001,
        MD_MULHSU = 3'b010,
        MD_MULHU  = 3'b011,
        MD_DIV    = 3'b100,
        MD_DIVU   = 3'b101,
        MD_REM    = 3'b110,
        MD_REMU   = 3'b111
    } muldiv_ops;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } muldiv_state_e;

endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit sitting beside the ALU in EX.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-low reset
//   start      in   EX issues an M-extension op this cycle
//   flush      in   squash the in-flight op
//   muldiv_op  in   funct3-encoded operation
//   a, b       in   rs1 / rs2 operands after forwarding
//   busy       out  op in flight, stalls IF/ID/EX
//   done       out  one-cycle pulse, f valid
//   f          out  result, held until the next done
//
// Operands are reduced to magnitudes at accept; the unsigned core runs
// 32 steps and the sign is fixed up on the final step.
module muldiv_unit
    import rv32i_types::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              flush,
    input  muldiv_ops         muldiv_op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] f
);

    function automatic logic [DATA_W-1:0] neg32(input logic [DATA_W-1:0] x, input logic en);
        return en ? (~x + 32'd1) : x;
    endfunction

    function automatic logic [2*DATA_W-1:0] neg64(input logic [2*DATA_W-1:0] x, input logic en);
        return en ? (~x + 64'd1) : x;
    endfunction

    muldiv_state_e       state, state_next;
    muldiv_ops           op_r;
    logic                neg_r;
    logic [DATA_W-1:0]   ma_r, mb_r;
    logic [2*DATA_W-1:0] acc_r;
    logic [4:0]          cnt_r;
    logic [DATA_W-1:0]   f_r;

    logic load, step, commit_fast, commit_calc;

    // Accept-time decode: magnitudes, result sign and the fast-path cases.
    logic              a_sgn, b_sgn, a_neg, b_neg, is_div, fast;
    logic [DATA_W-1:0] ma_in, mb_in, fast_result;
    logic              neg_in;

    always_comb begin
        is_div      = muldiv_op[2];
        a_sgn       = (muldiv_op == MD_MUL) || (muldiv_op == MD_MULH) || (muldiv_op == MD_MULHSU) ||
                      (muldiv_op == MD_DIV) || (muldiv_op == MD_REM);
        b_sgn       = (muldiv_op == MD_MUL) || (muldiv_op == MD_MULH) ||
                      (muldiv_op == MD_DIV) || (muldiv_op == MD_REM);
        a_neg       = a_sgn && a[DATA_W-1];
        b_neg       = b_sgn && b[DATA_W-1];
        ma_in       = neg32(a, a_neg);
        mb_in       = neg32(b, b_neg);
        // Remainder takes the dividend's sign; everything else the XOR.
        neg_in      = (is_div && muldiv_op[1]) ? a_neg : (a_neg ^ b_neg);
        fast        = 1'b0;
        fast_result = '0;
        if (is_div && (b == '0)) begin
            fast        = 1'b1;
            fast_result = muldiv_op[1] ? a : DIV_BY_ZERO;
        end else if (((muldiv_op == MD_DIV) || (muldiv_op == MD_REM)) &&
                     (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) begin
            fast        = 1'b1;
            fast_result = muldiv_op[1] ? 32'h0000_0000 : 32'h8000_0000;
        end
    end

    // One iteration of the unsigned core, plus the sign-fixed result that
    // would be committed if this is the last step.
    logic [DATA_W:0]     mul_sum;
    logic [DATA_W:0]     top;
    logic                ge;
    logic [DATA_W-1:0]   rem_sub, quo_rem, calc_result;
    logic [2*DATA_W-1:0] acc_step, prod_fix;

    always_comb begin
        mul_sum  = {1'b0, acc_r[63:32]} + (acc_r[0] ? {1'b0, ma_r} : 33'd0);
        top      = acc_r[63:31];
        ge       = (top >= {1'b0, mb_r});
        // Partial remainder stays below the divisor, so 32 bits suffice.
        rem_sub  = top[31:0] - mb_r;
        if (op_r[2]) begin
            acc_step = ge ? {rem_sub, acc_r[30:0], 1'b1} : {top[31:0], acc_r[30:0], 1'b0};
        end else begin
            acc_step = {mul_sum, acc_r[31:1]};
        end
        prod_fix = neg64(acc_step, neg_r);
        quo_rem  = op_r[1] ? acc_step[63:32] : acc_step[31:0];
        if (op_r[2]) begin
            calc_result = neg32(quo_rem, neg_r);
        end else if (op_r == MD_MUL) begin
            calc_result = prod_fix[31:0];
        end else begin
            calc_result = prod_fix[63:32];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        done        = 1'b0;
        load        = 1'b0;
        step        = 1'b0;
        commit_fast = 1'b0;
        commit_calc = 1'b0;
        busy        = (state != IDLE) || (start && !flush);
        case (state)
            IDLE: begin
                if (start && !flush) begin
                    load = 1'b1;
                    if (fast) begin
                        commit_fast = 1'b1;
                        state_next  = DONE;
                    end else begin
                        state_next  = CALC;
                    end
                end
            end
            CALC: begin
                if (flush) begin
                    state_next = IDLE;
                end else begin
                    step = 1'b1;
                    if (cnt_r == 5'(MULDIV_ITERS - 1)) begin
                        commit_calc = 1'b1;
                        state_next  = DONE;
                    end
                end
            end
            DONE: begin
                // Result is already committed, so a flush here cannot cancel it.
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            op_r  <= MD_MUL;
            neg_r <= 1'b0;
            ma_r  <= '0;
            mb_r  <= '0;
            acc_r <= '0;
            cnt_r <= '0;
            f_r   <= '0;
        end else begin
            if (load) begin
                op_r  <= muldiv_op;
                neg_r <= neg_in;
                ma_r  <= ma_in;
                mb_r  <= mb_in;
                // Multiply shifts the multiplier out of the low half;
                // divide shifts the dividend out of it.
                acc_r <= {32'd0, (is_div ? ma_in : mb_in)};
                cnt_r <= '0;
            end else if (step) begin
                acc_r <= acc_step;
                cnt_r <= cnt_r + 5'd1;
            end
            if (commit_fast) begin
                f_r <= fast_result;
            end else if (commit_calc) begin
                f_r <= calc_result;
            end
        end
    end

    assign f = f_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed testbench for muldiv_unit.
module tb_muldiv_unit;
    import rv32i_types::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        flush;
    muldiv_ops   muldiv_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] f;

    int checks = 0;
    int errors = 0;

    muldiv_unit dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .flush     (flush),
        .muldiv_op (muldiv_op),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .f         (f)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    // Cycle 0 presents start; done is expected exp_lat cycles later.
    task automatic run_op(input string tag, input muldiv_ops op, input logic [31:0] av,
                          input logic [31:0] bv, input logic [31:0] exp_f, input int exp_lat);
        logic [31:0] f_prev;
        logic        busy_ok;
        logic        f_stable;
        int          lat;
        f_prev    = f;
        muldiv_op = op;
        a         = av;
        b         = bv;
        start     = 1'b1;
        #2;
        busy_ok  = busy;
        f_stable = 1'b1;
        lat      = 0;
        for (int c = 1; c <= 40; c++) begin
            next_cycle;
            start = 1'b0;
            a     = $urandom;
            b     = $urandom;
            #2;
            if (!busy) busy_ok = 1'b0;
            if (!done && (f !== f_prev)) f_stable = 1'b0;
            if (done) begin
                lat = c;
                break;
            end
        end
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, " result"}, f, exp_f);
        chk({tag, " busy"}, {31'd0, busy_ok}, 32'd1);
        chk({tag, " f_hold"}, {31'd0, f_stable}, 32'd1);
        next_cycle;
        #2;
        chk({tag, " done_clear"}, {31'd0, done}, 32'd0);
        chk({tag, " idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic [31:0] f_prev;
        int          dones;
        int          lat;

        rst       = 1'b0;
        start     = 1'b0;
        flush     = 1'b0;
        muldiv_op = MD_MUL;
        a         = '0;
        b         = '0;
        next_cycle;
        next_cycle;
        #2;
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        chk("reset f", f, 32'h0);
        rst = 1'b1;
        next_cycle;

        // Multiply variants
        run_op("mulhu", MD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        run_op("mulh", MD_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33);
        run_op("mul", MD_MUL, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 33);
        run_op("mulhsu", MD_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 33);
        run_op("mul_neg", MD_MUL, 32'h0000_0003, 32'hFFFF_FFFB, 32'hFFFF_FFF1, 33);
        run_op("mulhu_big", MD_MULHU, 32'h8000_0000, 32'h0000_0004, 32'h0000_0002, 33);

        // Divide variants
        run_op("div", MD_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33);
        run_op("rem", MD_REM, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33);
        run_op("divu", MD_DIVU, 32'd100, 32'd7, 32'd14, 33);
        run_op("remu", MD_REMU, 32'd100, 32'd7, 32'd2, 33);
        run_op("div_negb", MD_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
        run_op("rem_negb", MD_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 33);
        run_op("divu_max", MD_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33);

        // Fast paths
        run_op("divu_by0", MD_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        run_op("remu_by0", MD_REMU, 32'd5, 32'd0, 32'd5, 1);
        run_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("rem_ovf", MD_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);

        // Flush mid-CALC at cycle 10, restart at cycle 12
        f_prev    = f;
        muldiv_op = MD_MUL;
        a         = 32'd3;
        b         = 32'd5;
        start     = 1'b1;
        dones     = 0;
        for (int c = 1; c <= 10; c++) begin
            next_cycle;
            start = 1'b0;
            if (c == 10) flush = 1'b1;
            #2;
            if (done) dones++;
        end
        next_cycle;
        flush = 1'b0;
        #2;
        if (done) dones++;
        chk("flush busy", {31'd0, busy}, 32'd0);
        chk("flush no_done", 32'(dones), 32'd0);
        chk("flush f_hold", f, f_prev);
        next_cycle;
        run_op("after_flush", MD_MUL, 32'd3, 32'd5, 32'd15, 33);

        // Flush and start together in IDLE
        muldiv_op = MD_DIVU;
        a         = 32'd9;
        b         = 32'd0;
        start     = 1'b1;
        flush     = 1'b1;
        #2;
        chk("flush_start busy", {31'd0, busy}, 32'd0);
        next_cycle;
        start = 1'b0;
        flush = 1'b0;
        #2;
        chk("flush_start done", {31'd0, done}, 32'd0);
        chk("flush_start idle", {31'd0, busy}, 32'd0);
        chk("flush_start f", f, 32'd15);

        // Flush during DONE keeps the pulse
        muldiv_op = MD_REMU;
        a         = 32'd5;
        b         = 32'd0;
        start     = 1'b1;
        next_cycle;
        start = 1'b0;
        flush = 1'b1;
        #2;
        chk("flush_done pulse", {31'd0, done}, 32'd1);
        chk("flush_done f", f, 32'd5);
        next_cycle;
        flush = 1'b0;
        #2;
        chk("flush_done after", {31'd0, done}, 32'd0);

        // Reset at cycle 20 of a divu
        muldiv_op = MD_DIVU;
        a         = 32'd100;
        b         = 32'd7;
        start     = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            next_cycle;
            start = 1'b0;
        end
        rst = 1'b0;
        next_cycle;
        rst = 1'b1;
        #2;
        chk("midrst busy", {31'd0, busy}, 32'd0);
        chk("midrst done", {31'd0, done}, 32'd0);
        chk("midrst f", f, 32'h0);
        dones = 0;
        for (int c = 0; c < 40; c++) begin
            next_cycle;
            #2;
            if (done) dones++;
        end
        chk("midrst no_done", 32'(dones), 32'd0);

        // start held high through CALC
        muldiv_op = MD_MULHU;
        a         = 32'hFFFF_FFFF;
        b         = 32'hFFFF_FFFF;
        start     = 1'b1;
        dones     = 0;
        lat       = 0;
        for (int c = 1; c <= 40; c++) begin
            next_cycle;
            #2;
            if (done) begin
                dones++;
                if (lat == 0) lat = c;
                start = 1'b0;
            end
        end
        chk("held latency", 32'(lat), 32'd33);
        chk("held one_done", 32'(dones), 32'd1);
        chk("held result", f, 32'hFFFF_FFFE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-low.
REQ-002 Port clk, input, 1: rising-edge clock.
REQ-003 Port rst, input, 1: synchronous active-low reset, sampled on clk rising edge.
REQ-004 Port start, input, 1: EX stage issues an M-extension op this cycle.
REQ-005 Port flush, input, 1: squash the in-flight op (branch mispredict or exception).
REQ-006 Port muldiv_op, input, muldiv_ops (3 bits): funct3-encoded mul, mulh, mulhsu, mulhu, div, divu, rem, remu.
REQ-007 Port a, input, 32: rs1 operand after EX forwarding mux.
REQ-008 Port b, input, 32: rs2 operand after EX forwarding mux.
REQ-009 Port busy, output, 1: op in flight; pipeline stalls IF/ID/EX while high.
REQ-010 Port done, output, 1: one-cycle pulse; f is valid this cycle.
REQ-011 Port f, output, 32: result, muxed with the ALU result into the EX/MEM register.

Function
REQ-012 States SHALL be IDLE, CALC, DONE; reset state is IDLE.
REQ-013 In IDLE with start=1 and flush=0: latch op, latch operand magnitudes and result-sign flags, clear the 5-bit iteration counter, go to CALC.
REQ-014 CALC SHALL perform one shift-add step (multiply) or one restoring-subtract step (divide) per cycle for exactly 32 cycles, then go to DONE.
REQ-015 Latency: done SHALL assert exactly 33 cycles after the edge that accepted start, for exactly one cycle; DONE then returns to IDLE.
REQ-016 busy SHALL be high in CALC and DONE, and also combinationally in IDLE while start=1 and flush=0.
REQ-017 Multiply SHALL form a 64-bit product. mul returns bits [31:0]; mulh, mulhsu, mulhu return bits [63:32]. Signedness: mulh both operands signed; mulhsu a signed, b unsigned; mulhu both unsigned.
REQ-018 Signed ops SHALL compute on magnitudes and two's-complement-negate the result when the sign flags require it.
REQ-019 Division SHALL truncate toward zero; the remainder sign SHALL equal the dividend sign.
REQ-020 Divide by zero (b=0): div/divu SHALL return 0xFFFFFFFF and rem/remu SHALL return a. Decided at start; skips CALC; done asserts one cycle after accept.
REQ-021 Signed overflow (div/rem with a=0x80000000, b=0xFFFFFFFF): div SHALL return 0x80000000 and rem SHALL return 0. Same one-cycle fast path.
REQ-022 f SHALL hold the last completed result until the next done. It SHALL NOT change during CALC.
REQ-023 start SHALL be ignored in CALC and DONE; operands are not re-latched.
REQ-024 flush=1 in any state SHALL force IDLE on the next edge: no done, f unchanged.
REQ-025 flush and start in the same IDLE cycle: flush wins and the op is not accepted.
REQ-026 flush in DONE SHALL still let that cycle's done pulse stand, since the result is already committed.

Reset
REQ-027 With rst=0 at an edge: state=IDLE, busy=0, done=0, f=0x00000000, counter=0, internal accumulators=0.
REQ-028 Reset mid-CALC SHALL abandon the op with no done pulse. Reset SHALL take priority over flush and start.

Structure
REQ-029 The muldiv_ops enum SHALL live in rv32i_types, alongside alu_ops.
REQ-030 The iteration count (32) and the div-by-zero constant SHALL be localparams in rv32i_types.
REQ-031 The block SHALL be a single module with no sub-module. The FSM, counter, 64-bit accumulator and sign-fix logic are all local.

Verification
REQ-032 mulhu a=0xFFFFFFFF, b=0xFFFFFFFF -> done at cycle 33, f=0xFFFFFFFE; busy high cycles 0-33.
REQ-033 mulh a=0xFFFFFFFF, b=0xFFFFFFFF -> f=0x00000000. mul a=0x00010000, b=0x00010000 -> f=0x00000000. mulhsu a=0xFFFFFFFF, b=0x00000002 -> f=0xFFFFFFFF.
REQ-034 div a=0xFFFFFFF9 (-7), b=2 -> f=0xFFFFFFFD. rem same operands -> f=0xFFFFFFFF. divu a=100, b=7 -> f=14.
REQ-035 divu a=5, b=0 -> f=0xFFFFFFFF, done one cycle after accept. remu a=5, b=0 -> f=5. div a=0x80000000, b=0xFFFFFFFF -> f=0x80000000.
REQ-036 Start mul, flush at cycle 10 -> IDLE at cycle 11, no done, f unchanged. A new start at cycle 12 completes normally at cycle 45.
REQ-037 rst=0 at cycle 20 of a divu -> all outputs zero next cycle, no done. start held high through CALC -> exactly one done.
